// File: rtl/psoc_dac_sched.sv
// Playback scheduler in front of psoc_dac: two-source round-robin frame FIFO,
// prefill-gated start, mute on underrun and a saturating underrun counter.
module psoc_dac_sched #(
    parameter int DEPTH       = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             src_mask,
    input  logic [47:0]            src0_data,
    input  logic                   src0_valid,
    output logic                   src0_ready,
    input  logic [47:0]            src1_data,
    input  logic                   src1_valid,
    output logic                   src1_ready,
    output logic [47:0]            dac_data,
    input  logic                   dac_ready,
    output logic                   dac_enable,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   underrun,
    output logic [15:0]            underrun_cnt,
    input  logic                   clr_stats
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [47:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rr_q, rr_d;  // 1: src1 wins when both sources are eligible
    logic [47:0]   dac_data_q, dac_data_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   ucnt_q, ucnt_d;

    logic          run_s, flush_s, full_s, empty_s;
    logic          elig0_s, elig1_s, grant0_s, grant1_s, push_s;
    logic          rd_req_s, pop_s, uflow_s;
    logic [47:0]   wdata_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_PRIME;
                else        state_d = ST_IDLE;
            end
            ST_PRIME: begin
                if (!enable)                          state_d = ST_IDLE;
                else if (count_q >= CW'(PRIME_LEVEL)) state_d = ST_RUN;
                else                                  state_d = ST_PRIME;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_IDLE;
                else         state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State decode; leaving RUN flushes the FIFO in that same cycle
    always_comb begin
        run_s   = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                run_s   = 1'b1;
                flush_s = ~enable;
            end
            default: begin
                run_s   = 1'b0;
                flush_s = 1'b0;
            end
        endcase
    end

    // Write arbitration and read request decode
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        empty_s  = (count_q == {CW{1'b0}});
        elig0_s  = src0_valid & src_mask[0] & ~full_s & ~flush_s;
        elig1_s  = src1_valid & src_mask[1] & ~full_s & ~flush_s;
        grant0_s = elig0_s & (~elig1_s | ~rr_q);
        grant1_s = elig1_s & (~elig0_s | rr_q);
        push_s   = grant0_s | grant1_s;
        if (grant1_s) wdata_s = src1_data;
        else          wdata_s = src0_data;
        rd_req_s = run_s & ~flush_s & dac_ready;
        pop_s    = rd_req_s & ~empty_s;
        uflow_s  = rd_req_s & empty_s;
    end

    // Datapath next-state: pointers, occupancy, output frame, statistics
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dac_data_d = dac_data_q;
        underrun_d = uflow_s;
        rr_d       = rr_q;
        if (flush_s) begin
            wr_ptr_d   = {AW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            count_d    = {CW{1'b0}};
            dac_data_d = 48'h0;
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
            else        wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
            else        rd_ptr_d = rd_ptr_q;
            count_d = count_q + CW'(push_s) - CW'(pop_s);
            if (pop_s)        dac_data_d = mem_q[rd_ptr_q];
            else if (uflow_s) dac_data_d = 48'h0;
            else              dac_data_d = dac_data_q;
        end
        if (grant0_s)      rr_d = 1'b1;
        else if (grant1_s) rr_d = 1'b0;
        else               rr_d = rr_q;
        if (clr_stats)                         ucnt_d = 16'h0000;
        else if (uflow_s && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'h0001;
        else                                   ucnt_d = ucnt_q;
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            rr_q       <= 1'b0;
            dac_data_q <= 48'h0;
            underrun_q <= 1'b0;
            ucnt_q     <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_q       <= rr_d;
            dac_data_q <= dac_data_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    // Frame storage; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q] <= wdata_s;
    end

    assign src0_ready   = grant0_s;
    assign src1_ready   = grant1_s;
    assign dac_enable   = run_s;
    assign dac_data     = dac_data_q;
    assign fill_level   = count_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_psoc_dac_sched.sv
// Scoreboard bench for psoc_dac_sched: a queue-based reference model predicts
// grants and post-edge outputs; a separate monitor compares them every cycle.
module tb_psoc_dac_sched;
    localparam int DEPTH       = 8;
    localparam int PRIME_LEVEL = 4;

    logic        clk = 1'b0;
    logic        rst, enable, clr_stats, dac_ready;
    logic [1:0]  src_mask;
    logic [47:0] src0_data, src1_data;
    logic        src0_valid, src1_valid, src0_ready, src1_ready;
    logic [47:0] dac_data;
    logic        dac_enable, underrun;
    logic [3:0]  fill_level;
    logic [15:0] underrun_cnt;

    always #5 clk = ~clk;

    psoc_dac_sched #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .src_mask(src_mask),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .dac_data(dac_data), .dac_ready(dac_ready), .dac_enable(dac_enable),
        .fill_level(fill_level), .underrun(underrun), .underrun_cnt(underrun_cnt),
        .clr_stats(clr_stats)
    );

    typedef struct packed {
        logic        chk_rdy;
        logic        r0;
        logic        r1;
        logic [47:0] data;
        logic [3:0]  fill;
        logic        den;
        logic        und;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: frame queue, playback phase, last granted source, stats
    logic [47:0] m_fifo[$];
    int          m_state = 0;   // 0 idle, 1 priming, 2 playing
    int          m_last  = 1;   // source granted most recently
    logic [47:0] m_data  = 48'h0;
    int          m_cnt   = 0;
    bit          m_known = 1'b0;

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic model_step();
        exp_t e;
        int   lvl;
        bit   fl, el0, el1, g0, g1, und;
        lvl = m_fifo.size();
        fl  = (m_state == 2) && !enable;
        el0 = src0_valid && src_mask[0] && (lvl < DEPTH) && !fl;
        el1 = src1_valid && src_mask[1] && (lvl < DEPTH) && !fl;
        g0  = 1'b0;
        g1  = 1'b0;
        if (el0 && el1) begin
            if (m_last == 0) g1 = 1'b1;
            else             g0 = 1'b1;
        end else begin
            g0 = el0;
            g1 = el1;
        end
        e.chk_rdy = m_known;
        e.r0 = g0;
        e.r1 = g1;
        und = 1'b0;
        if (rst) begin
            m_fifo.delete();
            m_state = 0;
            m_last  = 1;
            m_data  = 48'h0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else begin
            if (m_state == 2 && !fl && dac_ready) begin
                if (lvl > 0) begin
                    m_data = m_fifo.pop_front();
                end else begin
                    m_data = 48'h0;
                    und    = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (clr_stats) m_cnt = 0;
            if (g0) begin m_fifo.push_back(src0_data); m_last = 0; end
            if (g1) begin m_fifo.push_back(src1_data); m_last = 1; end
            if (fl) begin m_fifo.delete(); m_data = 48'h0; end
            case (m_state)
                0:       if (enable) m_state = 1;
                1:       if (!enable) m_state = 0; else if (lvl >= PRIME_LEVEL) m_state = 2;
                default: if (!enable) m_state = 0;
            endcase
        end
        e.data = m_data;
        e.fill = 4'(m_fifo.size());
        e.den  = (m_state == 2);
        e.und  = und;
        e.cnt  = 16'(m_cnt);
        sbq.push_back(e);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: grants before the edge, registered outputs after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq[0];
                if (e.chk_rdy) chk("ready", {62'h0, src0_ready, src1_ready}, {62'h0, e.r0, e.r1});
                @(posedge clk);
                #1;
                e = sbq.pop_front();
                chk("dac_data", 64'(dac_data), 64'(e.data));
                chk("fill_level", 64'(fill_level), 64'(e.fill));
                chk("dac_enable", 64'(dac_enable), 64'(e.den));
                chk("underrun", 64'(underrun), 64'(e.und));
                chk("underrun_cnt", 64'(underrun_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit en_prev;
        rst = 1'b1; enable = 1'b0; clr_stats = 1'b0; dac_ready = 1'b0;
        src_mask = 2'b00; src0_data = 48'h0; src1_data = 48'h0;
        src0_valid = 1'b0; src1_valid = 1'b0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;

        // Prefill with playback off, then start
        src_mask = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            src0_valid = 1'b1; src0_data = 48'(i); step();
        end
        src0_valid = 1'b0; step();
        enable = 1'b1; step(); step(); step();
        dac_ready = 1'b1; step();
        dac_ready = 1'b0; step(); step();

        // Round-robin with slow drain until full, then src1 masked
        src_mask = 2'b11; src0_valid = 1'b1; src1_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            src0_data = rnd48(); src1_data = rnd48();
            dac_ready = (i % 2 == 0); step();
        end
        src_mask = 2'b01;
        for (int i = 0; i < 6; i++) begin
            src0_data = rnd48(); src1_data = rnd48(); dac_ready = 1'b1; step();
        end

        // Drain into underruns, then clear together with an underrun
        src0_valid = 1'b0; src1_valid = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) step();
        clr_stats = 1'b1; step();
        clr_stats = 1'b0; dac_ready = 1'b0; step();

        // Push+pop at level 2, then push+pop on an empty FIFO
        src0_valid = 1'b1; src0_data = rnd48(); step();
        src0_data = rnd48(); step();
        src0_data = rnd48(); dac_ready = 1'b1; step();
        src0_valid = 1'b0; step(); step(); step();
        src0_valid = 1'b1; src0_data = rnd48(); step();

        // Fill to 5, then disable with a concurrent write offered
        dac_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin src0_data = rnd48(); step(); end
        enable = 1'b0; src0_data = rnd48(); step();
        src0_valid = 1'b0; step(); step();

        // Reach RUN, make two underruns, refill to 6, then reset
        enable = 1'b1; clr_stats = 1'b1; step();
        clr_stats = 1'b0; src0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin src0_data = rnd48(); step(); end
        src0_valid = 1'b0; step();
        dac_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        dac_ready = 1'b0; src0_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin src0_data = rnd48(); step(); end
        rst = 1'b1; dac_ready = 1'b1; step();
        rst = 1'b0; dac_ready = 1'b0; enable = 1'b0;
        src_mask = 2'b11; src1_valid = 1'b1;
        src0_data = rnd48(); src1_data = rnd48(); step();
        src0_data = rnd48(); src1_data = rnd48(); step();
        src0_valid = 1'b0; src1_valid = 1'b0; step();

        // Random traffic
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            en_prev    = enable;
            rst        = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            src_mask   = 2'($urandom);
            src0_valid = ($urandom_range(0, 3) == 0);
            src1_valid = ($urandom_range(0, 3) == 0);
            src0_data  = rnd48();
            src1_data  = rnd48();
            dac_ready  = ($urandom_range(0, 2) == 0) && !(en_prev && !enable);
            clr_stats  = ($urandom_range(0, 63) == 0);
            step();
        end

        // Drive the counter into saturation
        rst = 1'b1; enable = 1'b0; clr_stats = 1'b0; dac_ready = 1'b0;
        src0_valid = 1'b0; src1_valid = 1'b0; step();
        rst = 1'b0; enable = 1'b1; src_mask = 2'b01; src0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin src0_data = rnd48(); step(); end
        src0_valid = 1'b0; step();
        dac_ready = 1'b1;
        for (int i = 0; i < 65545; i++) step();
        clr_stats = 1'b1; step();
        clr_stats = 1'b0; step();
        dac_ready = 1'b0; step();

        for (int w = 0; w < 5 && sbq.size() > 0; w++) @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
